auto_count_ctrl: RTL and testbench

- Run-control sequencer for the auto 4-bit counter.
- Owns a programmable prescaler, replacing the free-running fixed divider, and produces single-cycle count-enable ticks.
- Keeps the 4-bit count value and sequences it through idle / run / pause / done, with single-step and one-shot modes.
- Sits between the board push-buttons/switches (already debounced) and the display/LED logic.

---
 rtl/auto_count_ctrl_if.sv | 29 ++
 rtl/auto_count_ctrl.sv | 150 +++++++++++++++
 tb/tb_auto_count_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/auto_count_ctrl_if.sv
// Command/status bundle between the board controls and the counter sequencer.
// The sequencer takes the slave side; the controlling side takes master.
interface auto_count_ctrl_if #(
    parameter int unsigned DIV_W = 25,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             stop;
    logic             step;
    logic             up_dn;
    logic             one_shot;
    logic             div_load;
    logic [DIV_W-1:0] div_val;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, stop, step, up_dn, one_shot, div_load, div_val,
        input  count, tick, busy, done, state
    );

    modport slave (
        input  start, stop, step, up_dn, one_shot, div_load, div_val,
        output count, tick, busy, done, state
    );
endinterface

// File: rtl/auto_count_ctrl.sv
// Run-control sequencer for the 4-bit counter: programmable prescaler, count register and
// idle/run/pause/done sequencing with single-step and one-shot modes.
module auto_count_ctrl #(
    parameter int unsigned DIV_W   = 25,
    parameter int unsigned DEF_DIV = 25,
    parameter int unsigned CNT_W   = 4
) (
    input logic              clk,
    input logic              reset,
    auto_count_ctrl_if.slave ctrl_io
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_reg_q, div_reg_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;

    logic             cmd_stop, cmd_start, cmd_step;
    logic             wrap, do_tick, hit_term;
    logic [CNT_W-1:0] count_upd;

    // Priority stop > start > step; losers in the same cycle are dropped.
    assign cmd_stop  = ctrl_io.stop;
    assign cmd_start = ctrl_io.start & ~ctrl_io.stop;
    assign cmd_step  = ctrl_io.step & ~ctrl_io.stop & ~ctrl_io.start;

    assign wrap      = (state_q == StRun) && (div_cnt_q == div_reg_q);
    assign do_tick   = wrap || (cmd_step && (state_q == StIdle || state_q == StPause));
    assign count_upd = ctrl_io.up_dn ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
    assign hit_term  = ctrl_io.one_shot && (count_upd == (ctrl_io.up_dn ? CntMax : '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            tick_q    <= 1'b0;
            div_cnt_q <= '0;
            div_reg_q <= DIV_W'(DEF_DIV);
            shadow_q  <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            div_cnt_q <= div_cnt_d;
            div_reg_q <= div_reg_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_start)                 state_d = StRun;
                else if (cmd_step && hit_term) state_d = StDone;
            end
            StRun: begin
                if (cmd_stop)              state_d = StPause;
                else if (wrap && hit_term) state_d = StDone;
            end
            StPause: begin
                if (cmd_stop)                  state_d = StIdle;
                else if (cmd_start)            state_d = StRun;
                else if (cmd_step && hit_term) state_d = StDone;
            end
            StDone: begin
                if (cmd_stop)       state_d = StIdle;
                else if (cmd_start) state_d = StRun;
            end
        endcase
    end

    always_comb begin
        count_d   = do_tick ? count_upd : count_q;
        tick_d    = do_tick;
        div_cnt_d = div_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_stop) begin
                    count_d   = '0;
                    div_cnt_d = '0;
                end else if (cmd_start) begin
                    div_cnt_d = '0;
                end
            end
            StRun: begin
                if (wrap)           div_cnt_d = '0;
                else if (!cmd_stop) div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            StPause: begin
                if (cmd_stop) begin
                    count_d   = '0;
                    div_cnt_d = '0;
                end
            end
            StDone: begin
                if (cmd_stop) begin
                    count_d   = '0;
                    div_cnt_d = '0;
                end else if (cmd_start) begin
                    count_d   = ctrl_io.up_dn ? '0 : CntMax;
                    div_cnt_d = '0;
                end
            end
        endcase
    end

    // Loads during RUN are deferred to the period boundary (or a pause) so the
    // period in flight is never cut short; a load landing on that edge applies directly.
    always_comb begin
        div_reg_d = div_reg_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        if (state_q == StRun) begin
            if (wrap || cmd_stop) begin
                if (ctrl_io.div_load)  div_reg_d = ctrl_io.div_val;
                else if (pend_q)       div_reg_d = shadow_q;
                pend_d = 1'b0;
            end else if (ctrl_io.div_load) begin
                shadow_d = ctrl_io.div_val;
                pend_d   = 1'b1;
            end
        end else if (ctrl_io.div_load) begin
            div_reg_d = ctrl_io.div_val;
        end
    end

    always_comb begin
        ctrl_io.count = count_q;
        ctrl_io.tick  = tick_q;
        ctrl_io.busy  = (state_q == StRun);
        ctrl_io.done  = (state_q == StDone);
        ctrl_io.state = state_q;
    end

endmodule

// File: tb/tb_auto_count_ctrl.sv
// Bench for auto_count_ctrl: a period/phase reference model checked every cycle, directed
// scenarios with literal timing pins, then randomized command traffic.
module tb_auto_count_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    auto_count_ctrl_if #(.DIV_W(25), .CNT_W(4)) bus ();

    auto_count_ctrl #(
        .DIV_W  (25),
        .DEF_DIV(25),
        .CNT_W  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ctrl_io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0..3 as on the state output, phase counts cycles into the
    // current prescaler period, period = terminal + 1.
    int m_mode, m_count, m_phase, m_period, m_shadow, m_pending, m_tick;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit stp, sta, ste, boundary, term;
        int nxt;
        stp  = bus.stop;
        sta  = bus.start && !stp;
        ste  = bus.step && !stp && !sta;
        nxt  = (m_count + (bus.up_dn ? 1 : 15)) % 16;
        term = bus.one_shot && (nxt == (bus.up_dn ? 15 : 0));
        m_tick = 0;
        if (!reset) begin
            m_mode = 0; m_count = 0; m_phase = 0; m_period = 26; m_pending = 0;
            return;
        end
        case (m_mode)
            1: begin
                boundary = (m_phase == m_period - 1);
                if (boundary || stp) begin
                    if (bus.div_load)   m_period = int'(bus.div_val) + 1;
                    else if (m_pending) m_period = m_shadow + 1;
                    m_pending = 0;
                end else if (bus.div_load) begin
                    m_shadow  = int'(bus.div_val);
                    m_pending = 1;
                end
                if (boundary) begin
                    m_tick = 1; m_count = nxt; m_phase = 0;
                end else if (!stp) begin
                    m_phase++;
                end
                if (stp)                   m_mode = 2;
                else if (boundary && term) m_mode = 3;
            end
            default: begin
                if (bus.div_load) m_period = int'(bus.div_val) + 1;
                if (stp) begin
                    if (m_mode == 2 || m_mode == 3) m_mode = 0;
                    m_count = 0; m_phase = 0;
                end else if (sta) begin
                    if (m_mode == 3) m_count = bus.up_dn ? 0 : 15;
                    if (m_mode != 2) m_phase = 0;
                    m_mode = 1;
                end else if (ste && m_mode != 3) begin
                    m_tick = 1; m_count = nxt;
                    if (term) m_mode = 3;
                end
            end
        endcase
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", int'(bus.count), m_count);
            chk("tick", int'(bus.tick), m_tick);
            chk("state", int'(bus.state), m_mode);
            chk("busy", int'(bus.busy), int'(m_mode == 1));
            chk("done", int'(bus.done), int'(m_mode == 3));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    endtask

    task automatic load_div(input int v);
        bus.div_load = 1'b1; bus.div_val = 25'(v); cyc(); bus.div_load = 1'b0;
    endtask

    // Cycles until the next tick, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.tick && n < 200);
        if (!bus.tick) chk("tick_timeout", 0, 1);
    endtask

    initial begin
        int n, nt, total;
        n_tests = 0; n_fail = 0; chk_en = 0;
        m_mode = 0; m_count = 0; m_phase = 0; m_period = 26; m_shadow = 0; m_pending = 0;
        m_tick = 0;
        reset = 1'b0;
        bus.start = 0; bus.stop = 0; bus.step = 0; bus.up_dn = 1; bus.one_shot = 0;
        bus.div_load = 0; bus.div_val = '0;
        cyc();
        chk_en = 1;
        repeat (2) cyc();
        chk("rst_count", int'(bus.count), 0);
        chk("rst_state", int'(bus.state), 0);
        reset = 1'b1;

        // Free run at the default divider
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            wait_tick(n);
            chk("period26", n, 26);
        end
        chk("wrap_to_0", int'(bus.count), 0);

        // Pause and resume with div_cnt held
        pulse_stop();
        pulse_stop();
        load_div(3);
        pulse_start();
        wait_tick(n); chk("p4_a", n, 4);
        wait_tick(n); chk("p4_b", n, 4);
        cyc(); cyc();
        pulse_stop();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("pause_count", int'(bus.count), 2);
            chk("pause_state", int'(bus.state), 2);
        end
        pulse_start();
        wait_tick(n); chk("resume_gap", n, 2);
        wait_tick(n); chk("resume_period", n, 4);

        // Step while idle, counting down
        pulse_stop();
        pulse_stop();
        bus.up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b1; cyc(); bus.step = 1'b0;
            chk("step_tick", int'(bus.tick), 1);
            chk("step_count", int'(bus.count), 15 - i);
            chk("step_state", int'(bus.state), 0);
        end
        pulse_stop();
        chk("idle_clear", int'(bus.count), 0);

        // One-shot with a tick every cycle
        load_div(0);
        bus.one_shot = 1'b1; bus.up_dn = 1'b1;
        pulse_start();
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.tick) nt++;
            if (bus.done) break;
        end
        chk("os_ticks", nt, 15);
        chk("os_count", int'(bus.count), 15);
        chk("os_done", int'(bus.done), 1);
        chk("os_busy", int'(bus.busy), 0);
        chk("os_state", int'(bus.state), 3);
        pulse_start();
        chk("restart_count", int'(bus.count), 0);
        chk("restart_state", int'(bus.state), 1);
        bus.one_shot = 1'b0;
        pulse_stop();
        pulse_stop();

        // Reload while running takes effect at the next wrap
        load_div(7);
        pulse_start();
        repeat (3) cyc();
        bus.div_load = 1'b1; bus.div_val = 25'd1; cyc(); bus.div_load = 1'b0;
        wait_tick(n);
        total = 4 + n;
        chk("reload_cur", total, 8);
        wait_tick(n); chk("reload_new_a", n, 2);
        wait_tick(n); chk("reload_new_b", n, 2);

        // Stop beats start; reset mid-run restores the default divider
        bus.start = 1'b1; bus.stop = 1'b1; cyc(); bus.start = 1'b0; bus.stop = 1'b0;
        chk("prio_state", int'(bus.state), 2);
        pulse_start();
        reset = 1'b0; cyc(); reset = 1'b1;
        chk("midrst_count", int'(bus.count), 0);
        chk("midrst_state", int'(bus.state), 0);
        pulse_start();
        wait_tick(n); chk("midrst_period", n, 26);

        // Randomized command traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.start    = ($urandom % 14) == 0;
            bus.stop     = ($urandom % 22) == 0;
            bus.step     = ($urandom % 10) == 0;
            bus.div_load = ($urandom % 18) == 0;
            bus.div_val  = 25'($urandom_range(0, 5));
            if (($urandom % 8) == 0)  bus.up_dn = ~bus.up_dn;
            if (($urandom % 40) == 0) bus.one_shot = ~bus.one_shot;
            reset = ($urandom % 500) != 0;
            cyc();
        end
        bus.start = 0; bus.stop = 0; bus.step = 0; bus.div_load = 0; reset = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
